rho_rotate: RTL and testbench

//  Rho stage of the encoder permutation, directly downstream of column parity (theta).

---
 rtl/encoder_pkg.sv | 47 ++++
 rtl/rho_offset_rom.sv | 14 +
 rtl/rho_rotate.sv | 80 ++++++++
 tb/tb_rho_rotate.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared permutation constants, rho FSM encoding and rho offset table
package encoder_pkg;

    localparam int LANES  = 25;
    localparam int LANE_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ROT   = 3'd3,
        ST_WRITE = 3'd4
    } rho_state_e;

    // Keccak rho offsets indexed by lane x+5y
    function automatic int unsigned rho_offset(input logic [4:0] lane);
        case (lane)
            5'd0:  return 0;
            5'd1:  return 1;
            5'd2:  return 62;
            5'd3:  return 28;
            5'd4:  return 27;
            5'd5:  return 36;
            5'd6:  return 44;
            5'd7:  return 6;
            5'd8:  return 55;
            5'd9:  return 20;
            5'd10: return 3;
            5'd11: return 10;
            5'd12: return 43;
            5'd13: return 25;
            5'd14: return 39;
            5'd15: return 41;
            5'd16: return 45;
            5'd17: return 15;
            5'd18: return 21;
            5'd19: return 8;
            5'd20: return 18;
            5'd21: return 2;
            5'd22: return 61;
            5'd23: return 56;
            5'd24: return 14;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/rho_offset_rom.sv
// rtl/rho_offset_rom.sv - combinational lane index to rotate count, reduced mod lane width
module rho_offset_rom
    import encoder_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 6
) (
    input  logic [4:0]       lane,
    output logic [CNT_W-1:0] offset
);

    assign offset = CNT_W'(rho_offset(lane) % W);

endmodule

// File: rtl/rho_rotate.sv
// rtl/rho_rotate.sv - rho stage: reads each of 25 lanes, rotates left one bit per cycle, writes it back out
module rho_rotate
    import encoder_pkg::*;
#(
    parameter int W     = LANE_W,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         src_rd,
    output logic [4:0]   src_addr,
    input  logic [W-1:0] src_data,
    output logic         dst_wr,
    output logic [4:0]   dst_addr,
    output logic [W-1:0] dst_data,
    output logic         ready
);

    rho_state_e       state, state_nxt;
    logic [4:0]       lane;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rom_off;
    logic [W-1:0]     sr;
    logic [W-1:0]     dst_hold;

    rho_offset_rom #(.W(W), .CNT_W(CNT_W)) u_rom (
        .lane   (lane),
        .offset (rom_off)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            lane     <= '0;
            cnt      <= '0;
            sr       <= '0;
            dst_hold <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start) lane <= '0;
                ST_LOAD: begin
                    sr  <= src_data;
                    cnt <= rom_off;
                end
                ST_ROT: begin
                    sr  <= {sr[W-2:0], sr[W-1]};
                    cnt <= cnt - CNT_W'(1);
                end
                ST_WRITE: begin
                    dst_hold <= sr;
                    if (lane != 5'(LANES - 1)) lane <= lane + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = (rom_off != '0) ? ST_ROT : ST_WRITE;
            ST_ROT:   if (cnt == CNT_W'(1)) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (lane == 5'(LANES - 1)) ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // lane only advances on WRITE->READ, so both addresses hold steady between strobes
    assign src_rd   = (state == ST_READ);
    assign src_addr = lane;
    assign dst_wr   = (state == ST_WRITE);
    assign dst_addr = lane;
    assign dst_data = (state == ST_WRITE) ? sr : dst_hold;
    assign ready    = (state == ST_IDLE);

endmodule

// File: tb/tb_rho_rotate.sv
// tb/tb_rho_rotate.sv - directed and table-driven bench for rho_rotate
module tb_rho_rotate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        src_rd;
    logic [4:0]  src_addr;
    logic [63:0] src_data = '0;
    logic        dst_wr;
    logic [4:0]  dst_addr;
    logic [63:0] dst_data;
    logic        ready;

    rho_rotate #(.W(64), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_rd   (src_rd),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_wr   (dst_wr),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    int unsigned rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20,
                                 3, 10, 43, 25, 39, 41, 45, 15, 21, 8,
                                 18, 2, 61, 56, 14};

    logic [63:0] mem [25];
    logic [63:0] dst_mem [25];
    int          wr_addr [512];
    int          wr_cyc  [512];
    int          nwr = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          rdy_cyc = 0;
    logic        prev_ready = 1'b1;
    int          nvec = 0;
    int          nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (src_rd) src_data <= mem[src_addr];

    always @(negedge clk) begin
        if (dst_wr && nwr < 512) begin
            wr_addr[nwr] = int'(dst_addr);
            wr_cyc[nwr]  = cyc - t0;
            dst_mem[dst_addr] = dst_data;
            nwr = nwr + 1;
        end
        if (ready && !prev_ready) rdy_cyc = cyc - t0;
        prev_ready = ready;
    end

    function automatic logic [63:0] rol(input logic [63:0] x, input int unsigned r);
        logic [63:0] y;
        y = x;
        for (int k = 0; k < int'(r); k++) y = {y[62:0], y[63]};
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one pass from a single start pulse; optionally re-pulses start at pass cycles 10 and 400
    task automatic run_pass(input bit extra);
        bit done;
        done = 1'b0;
        @(negedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 900 && !done; i++) begin
            @(negedge clk); #1;
            start = extra && ((cyc - t0 == 10) || (cyc - t0 == 400));
            if (ready) done = 1'b1;
        end
        start = 1'b0;
        if (!done) chk("pass_timeout", 64'(ready), 64'd1);
        @(negedge clk); #1;
    endtask

    typedef struct {
        logic [63:0] pat;
        int          lane;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] cur_pat;
    int          base;
    bit          done;

    initial begin
        vecs[0]  = '{64'h1, 0,  64'h1};
        vecs[1]  = '{64'h1, 1,  64'h2};
        vecs[2]  = '{64'h1, 2,  64'h4000_0000_0000_0000};
        vecs[3]  = '{64'h1, 23, 64'h0100_0000_0000_0000};
        vecs[4]  = '{64'h1, 24, 64'h0000_0000_0000_4000};
        vecs[5]  = '{64'h8000_0000_0000_0001, 0,  64'h8000_0000_0000_0001};
        vecs[6]  = '{64'h8000_0000_0000_0001, 1,  64'h3};
        vecs[7]  = '{64'h8000_0000_0000_0001, 2,  64'h6000_0000_0000_0000};
        vecs[8]  = '{64'h8000_0000_0000_0001, 5,  64'h0000_0018_0000_0000};
        vecs[9]  = '{64'h8000_0000_0000_0001, 22, 64'h3000_0000_0000_0000};
        vecs[10] = '{64'h0123_4567_89AB_CDEF, 1,  64'h0246_8ACF_1357_9BDE};
        vecs[11] = '{64'h0123_4567_89AB_CDEF, 0,  64'h0123_4567_89AB_CDEF};

        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready",    64'(ready),    64'd1);
        chk("reset_src_rd",   64'(src_rd),   64'd0);
        chk("reset_dst_wr",   64'(dst_wr),   64'd0);
        chk("reset_src_addr", 64'(src_addr), 64'd0);
        chk("reset_dst_addr", 64'(dst_addr), 64'd0);
        chk("reset_dst_data", dst_data,      64'd0);
        @(negedge clk);
        rst = 1'b1;

        // table-driven lane checks; a new pass is run whenever the fill pattern changes
        cur_pat = 64'hx;
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].pat !== cur_pat) begin
                cur_pat = vecs[v].pat;
                for (int i = 0; i < 25; i++) mem[i] = cur_pat;
                run_pass(1'b0);
            end
            chk($sformatf("vec%0d_lane%0d", v, vecs[v].lane), dst_mem[vecs[v].lane], vecs[v].exp);
        end

        // timing, ordering and ignored mid-pass start pulses
        for (int i = 0; i < 25; i++) mem[i] = 64'h1;
        base = nwr;
        run_pass(1'b1);
        chk("write_count", 64'(nwr - base), 64'd25);
        for (int k = 0; k < 25; k++)
            chk($sformatf("write_order_%0d", k), 64'(wr_addr[base + k]), 64'(k));
        chk("first_write_cycle", 64'(wr_cyc[base]),      64'd3);
        chk("last_write_cycle",  64'(wr_cyc[base + 24]), 64'd755);
        chk("ready_cycle",       64'(rdy_cyc),           64'd756);

        // random state against the ROL reference
        for (int i = 0; i < 25; i++) mem[i] = {$urandom, $urandom};
        run_pass(1'b0);
        for (int i = 0; i < 25; i++)
            chk($sformatf("random_lane%0d", i), dst_mem[i], rol(mem[i], rho_tb[i]));

        // reset at pass cycle 300 aborts immediately and nothing follows until a new start
        @(negedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        while (cyc - t0 < 300) begin
            @(negedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("abort_ready",  64'(ready),  64'd1);
        chk("abort_dst_wr", 64'(dst_wr), 64'd0);
        chk("abort_src_rd", 64'(src_rd), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = nwr;
        repeat (800) @(negedge clk);
        #1;
        chk("abort_no_writes", 64'(nwr - base), 64'd0);
        chk("abort_idle",      64'(ready),      64'd1);

        // start held high relaunches on the first IDLE edge
        base = nwr;
        @(negedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk); #1;
            if (nwr - base >= 50) done = 1'b1;
        end
        start = 1'b0;
        if (!done) chk("held_timeout", 64'(nwr - base), 64'd50);
        chk("held_pass1_last", 64'(wr_cyc[base + 24]), 64'd755);
        chk("held_pass2_first", 64'(wr_cyc[base + 25]), 64'd759);
        chk("held_pass2_addr0", 64'(wr_addr[base + 25]), 64'd0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); #1;
            if (ready) done = 1'b1;
        end
        chk("held_final_idle", 64'(ready), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("held_total_writes", 64'(nwr - base), 64'd50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
